// File: rtl/info_table_parser_pkg.sv
// rtl/info_table_parser_pkg.sv - shared constants, state encoding and index helper for the info table printer/parser
package info_table_parser_pkg;

    localparam int DIM_MAX = 5;
    localparam int ENTRY_W = 2;
    localparam int ENTRIES = DIM_MAX * DIM_MAX;
    localparam int TABLE_W = ENTRIES * ENTRY_W;

    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_1     = 8'h31;
    localparam logic [7:0] ASCII_2     = 8'h32;
    localparam logic [7:0] ASCII_3     = 8'h33;
    localparam logic [7:0] ASCII_4     = 8'h34;
    localparam logic [7:0] ASCII_5     = 8'h35;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_M     = 4'd1;
    localparam logic [3:0] ST_STAR1 = 4'd2;
    localparam logic [3:0] ST_N     = 4'd3;
    localparam logic [3:0] ST_STAR2 = 4'd4;
    localparam logic [3:0] ST_C     = 4'd5;
    localparam logic [3:0] ST_SEP   = 4'd6;
    localparam logic [3:0] ST_ERR   = 4'd7;
    localparam logic [3:0] ST_SUM   = 4'd8;
    localparam logic [3:0] ST_DONE  = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE  = ST_IDLE,
        S_M     = ST_M,
        S_STAR1 = ST_STAR1,
        S_N     = ST_N,
        S_STAR2 = ST_STAR2,
        S_C     = ST_C,
        S_SEP   = ST_SEP,
        S_ERR   = ST_ERR,
        S_SUM   = ST_SUM,
        S_DONE  = ST_DONE
    } parse_state_t;

    // m and n are 1-based dimensions in 1..DIM_MAX
    function automatic logic [4:0] entry_idx(input logic [2:0] m, input logic [2:0] n);
        return 5'((int'(m) - 1) * DIM_MAX + (int'(n) - 1));
    endfunction

endpackage

// File: rtl/info_table_parser.sv
// rtl/info_table_parser.sv - parses "m*n*c" ASCII records into a shadow table and commits it atomically at end of frame
module info_table_parser
    import info_table_parser_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR = ASCII_LF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [TABLE_W-1:0] info_table,
    output logic [5:0]         total_count,
    output logic               busy,
    output logic               done,
    output logic               error
);

    parse_state_t       state_q, state_d, parse_st;
    logic [2:0]         m_q, m_d, n_q, n_d;
    logic [TABLE_W-1:0] shadow_q, shadow_d, table_q, table_d;
    logic [5:0]         sum_q, sum_d, total_q, total_d;
    logic [4:0]         idx_q, idx_d;
    logic               error_q, error_d;
    logic               accept, fail, is_term, is_dim, is_cnt;
    logic [ENTRY_W-1:0] entry;

    assign din_ready   = (state_q != S_SUM) && (state_q != S_DONE);
    assign accept      = din_valid && din_ready;
    assign is_term     = (din == TERM_CHAR);
    assign is_dim      = (din >= ASCII_1) && (din <= ASCII_5);
    assign is_cnt      = (din >= ASCII_0) && (din <= ASCII_3);
    assign entry       = shadow_q[{idx_q, 1'b0} +: ENTRY_W];

    assign info_table  = table_q;
    assign total_count = total_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign error       = error_q;

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        n_d      = n_q;
        shadow_d = shadow_q;
        table_d  = table_q;
        total_d  = total_q;
        error_d  = error_q;
        sum_d    = '0;
        idx_d    = '0;
        fail     = 1'b0;
        parse_st = state_q;

        // The first byte of a frame is parsed as if already in S_M
        if (state_q == S_IDLE && accept) begin
            shadow_d = '0;
            error_d  = 1'b0;
            parse_st = S_M;
        end

        case (parse_st)
            S_SUM: begin
                sum_d = sum_q + 6'(entry);
                idx_d = idx_q + 5'd1;
                if (idx_q == 5'(ENTRIES - 1)) begin
                    table_d = shadow_q;
                    total_d = sum_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: if (accept) begin
                case (parse_st)
                    S_M: begin
                        if (din == ASCII_SPACE) state_d = S_M;
                        else if (is_dim) begin
                            m_d     = din[2:0];
                            state_d = S_STAR1;
                        end
                        else if (is_term) state_d = S_SUM;
                        else state_d = S_ERR;
                    end
                    S_STAR1: if (din == ASCII_STAR) state_d = S_N; else fail = 1'b1;
                    S_N: begin
                        if (is_dim) begin
                            n_d     = din[2:0];
                            state_d = S_STAR2;
                        end
                        else fail = 1'b1;
                    end
                    S_STAR2: if (din == ASCII_STAR) state_d = S_C; else fail = 1'b1;
                    S_C: begin
                        if (is_cnt) begin
                            shadow_d[{entry_idx(m_q, n_q), 1'b0} +: ENTRY_W] = din[1:0];
                            state_d = S_SEP;
                        end
                        else fail = 1'b1;
                    end
                    S_SEP: begin
                        if (din == ASCII_SPACE) state_d = S_M;
                        else if (is_term) state_d = S_SUM;
                        else state_d = S_ERR;
                    end
                    S_ERR: fail = 1'b1;
                    default: ;
                endcase
            end
        endcase

        if (fail) begin
            if (is_term) begin
                state_d = S_DONE;
                error_d = 1'b1;
            end
            else state_d = S_ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            n_q      <= '0;
            shadow_q <= '0;
            table_q  <= '0;
            sum_q    <= '0;
            total_q  <= '0;
            idx_q    <= '0;
            error_q  <= 1'b0;
        end
        else begin
            state_q  <= state_d;
            m_q      <= m_d;
            n_q      <= n_d;
            shadow_q <= shadow_d;
            table_q  <= table_d;
            sum_q    <= sum_d;
            total_q  <= total_d;
            idx_q    <= idx_d;
            error_q  <= error_d;
        end
    end

endmodule

// File: tb/tb_info_table_parser.sv
// tb/tb_info_table_parser.sv - directed self-checking bench for info_table_parser
module tb_info_table_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [49:0] info_table;
    logic [5:0]  total_count;
    logic        busy, done, error;

    int checks = 0;
    int errors = 0;

    info_table_parser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .info_table (info_table),
        .total_count(total_count),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        din       = b;
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!din_ready) begin
            checks++; errors++;
            $display("FAIL send_byte_timeout: din_ready=%0b required 1", din_ready);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_commit(input string name, input logic [49:0] exp_tab, input logic [5:0] exp_tot);
        int cyc;
        wait_done(cyc);
        checks++;
        if (cyc !== 25) begin
            errors++;
            $display("FAIL %s latency: got %0d edges after LF required 25", name, cyc);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_busy: done=%0b busy=%0b required done=1 busy=0", name, done, busy);
        end
        checks++;
        if (info_table !== exp_tab) begin
            errors++;
            $display("FAIL %s table: got %h required %h", name, info_table, exp_tab);
        end
        checks++;
        if (total_count !== exp_tot || error !== 1'b0) begin
            errors++;
            $display("FAIL %s total_err: total=%0d error=%0b required total=%0d error=0", name, total_count, error, exp_tot);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%0b required 0", name, done);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (din_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%0b busy=%0b done=%0b error=%0b required 1 0 0 0", din_ready, busy, done, error);
        end
        checks++;
        if (info_table !== 50'h0 || total_count !== 6'd0) begin
            errors++;
            $display("FAIL reset_table: table=%h total=%0d required 0 0", info_table, total_count);
        end
    endtask

    task automatic test_basic();
        logic [49:0] exp = '0;
        exp[15:14] = 2'b01;
        exp[49:48] = 2'b11;
        send_str("2*3*1 5*5*3 ");
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%0b required 1", busy);
        end
        send_byte(8'h0A);
        check_commit("basic", exp, 6'd4);
    endtask

    task automatic test_last_write();
        logic [49:0] exp = '0;
        exp[1:0] = 2'b01;
        send_str("1*1*2 1*1*1\n");
        check_commit("last_write", exp, 6'd1);
    endtask

    task automatic test_error();
        logic [49:0] prev_tab = '0;
        logic [49:0] exp = '0;
        prev_tab[1:0] = 2'b01;
        send_str("2*7*1\n");
        checks++;
        if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_done: done=%0b error=%0b busy=%0b required 1 1 0", done, error, busy);
        end
        checks++;
        if (info_table !== prev_tab || total_count !== 6'd1) begin
            errors++;
            $display("FAIL err_keep: table=%h total=%0d required %h 1", info_table, total_count, prev_tab);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: done=%0b error=%0b required 0 1", done, error);
        end
        send_str("4*\n");
        checks++;
        if (done !== 1'b1 || error !== 1'b1 || info_table !== prev_tab) begin
            errors++;
            $display("FAIL err_trunc: done=%0b error=%0b table=%h required 1 1 %h", done, error, info_table, prev_tab);
        end
        send_byte("3");
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: error=%0b busy=%0b required 0 1", error, busy);
        end
        exp[25:24] = 2'b10;
        send_str("*3*2\n");
        check_commit("after_err", exp, 6'd2);
    endtask

    task automatic test_empty();
        send_str("\n");
        check_commit("empty", 50'h0, 6'd0);
        send_str("1*1*3\n");
        check_commit("prefill", 50'h3, 6'd3);
        send_str("  \n");
        check_commit("spaces", 50'h0, 6'd0);
    endtask

    task automatic test_back_to_back();
        logic [49:0] exp = '0;
        int stall = 0;
        exp[9:8] = 2'b10;
        send_str("1*5*2\n");
        din       = "5";
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && stall < 100) begin
            stall++;
            @(negedge clk);
        end
        checks++;
        if (stall !== 26) begin
            errors++;
            $display("FAIL b2b_stall: got %0d cycles not ready required 26", stall);
        end
        checks++;
        if (info_table !== exp || total_count !== 6'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_commit: table=%h total=%0d busy=%0b required %h 2 0", info_table, total_count, busy, exp);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy: busy=%0b required 1", busy);
        end
        exp = '0;
        exp[41:40] = 2'b01;
        send_str("*1*1\n");
        check_commit("b2b_second", exp, 6'd1);
    endtask

    task automatic test_reset_mid();
        logic [49:0] exp = '0;
        exp[3:2] = 2'b11;
        send_str("3*4*");
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (info_table !== 50'h0 || total_count !== 6'd0 || busy !== 1'b0 || din_ready !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: table=%h total=%0d busy=%0b ready=%0b error=%0b required 0 0 0 1 0", info_table, total_count, busy, din_ready, error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_str("1*2*3\n");
        check_commit("post_reset", exp, 6'd3);
    endtask

    initial begin
        #2;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_basic();
        test_last_write();
        test_error();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
